// File: rtl/aud_recorder.sv
// aud_recorder: deserializes I2S ADC samples (BCLK domain) into one-cycle SRAM word writes.
// Optional build macro AUD_RECORDER_STEREO_EN captures both channels, interleaved L,R.
module aud_recorder #(
  parameter int                ADDR_W   = 20,
  parameter int                SAMPLE_W = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_lrc,
  input  logic                i_data,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  output logic [ADDR_W-1:0]   o_address,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_wen,
  output logic                o_done,
  output logic [ADDR_W-1:0]   o_len,
  output logic [2:0]          o_state
);

  // Write port: o_wen is a one-cycle valid strobe with o_address/o_data; there is no
  // ready, the SRAM must accept every strobe, and strobes are never on adjacent cycles.

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                lrc_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-2:0] shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                wen_q, wen_d;
  logic                done_q, done_d;
  logic                pause_q, pause_d;
  logic                edge_hit;
  logic                wait_pause_ok;
  logic                write_pause_ok;

`ifdef AUD_RECORDER_STEREO_EN
  // ch_q is the channel of the next sample to capture (0 = left, 1 = right).
  logic ch_q, ch_d;
  assign edge_hit       = ch_q ? (~lrc_q & i_lrc) : (lrc_q & ~i_lrc);
  assign wait_pause_ok  = ~ch_q;
  assign write_pause_ok = ch_q;
`else
  assign edge_hit       = lrc_q & ~i_lrc;
  assign wait_pause_ok  = 1'b1;
  assign write_pause_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    pause_d = pause_q;
`ifdef AUD_RECORDER_STEREO_EN
    ch_d    = ch_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!i_stop && !i_pause && i_start) begin
          state_d = S_WAIT;
          addr_d  = '0;
          len_d   = '0;
          pause_d = 1'b0;
`ifdef AUD_RECORDER_STEREO_EN
          ch_d    = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (i_stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pause_d = 1'b0;
        end else if ((i_pause || pause_q) && wait_pause_ok) begin
          state_d = S_PAUSE;
          pause_d = 1'b0;
        end else begin
          // Mid-pair pause request is held until the right sample is written.
          if (i_pause) pause_d = 1'b1;
          if (edge_hit) begin
            state_d = S_CAPTURE;
            cnt_d   = '0;
          end
        end
      end
      S_CAPTURE: begin
        if (i_stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pause_d = 1'b0;
        end else begin
          shift_d = {shift_q[SAMPLE_W-3:0], i_data};
          cnt_d   = cnt_q + CNT_W'(1);
          if (i_pause) pause_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_WRITE;
            wen_d   = 1'b1;
            data_d  = {shift_q, i_data};
          end
        end
      end
      S_WRITE: begin
        len_d = (len_q == MAX_ADDR) ? len_q : len_q + ADDR_W'(1);
`ifdef AUD_RECORDER_STEREO_EN
        ch_d  = ~ch_q;
`endif
        if (addr_q == MAX_ADDR) begin
          // Memory full: the last address is kept, recording ends.
          state_d = S_IDLE;
          done_d  = 1'b1;
          pause_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (i_stop) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pause_d = 1'b0;
          end else if ((pause_q || i_pause) && write_pause_ok) begin
            state_d = S_PAUSE;
            pause_d = 1'b0;
          end else begin
            state_d = S_WAIT;
            if (i_pause) pause_d = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (i_stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (!i_pause && i_start) begin
          state_d = S_WAIT;
`ifdef AUD_RECORDER_STEREO_EN
          ch_d    = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      lrc_q   <= 1'b1;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lrc_q   <= i_lrc;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      pause_q <= pause_d;
    end
  end

`ifdef AUD_RECORDER_STEREO_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ch_q <= 1'b0;
    else          ch_q <= ch_d;
  end
`endif

  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_wen     = wen_q;
  assign o_done    = done_q;
  assign o_len     = len_q;
  assign o_state   = state_q;

endmodule
